// File: rtl/timebase_rng_pkg.sv
// ---------------------------------------------------------------------------
// timebase_rng_pkg
//   Shared constants and helpers for the reaction-time monitor timebase:
//   - LFSR tap mask, default seed and the single-step next-state function
//   - divider presets for the supported system clocks
//   - random-delay range presets for the reaction-delay generator
//   - divider operation encoding used by the timebase control decode
// ---------------------------------------------------------------------------
package timebase_rng_pkg;

    // 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    // With a left shift the taps sit at state bits 15, 13, 12 and 10.
    localparam int          LFSR_W            = 16;
    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Divisor presets giving a 1 s tick. The 100 MHz preset needs a
    // divider at least 27 bits wide.
    localparam int DIV_DEFAULT_50MHZ  = 50_000_000;
    localparam int DIV_DEFAULT_100MHZ = 100_000_000;

    // Reaction-delay range: RAND_MIN .. RAND_MIN + 2^RAND_BITS - 1 ticks.
    localparam int REACT_RAND_W    = 13;
    localparam int REACT_RAND_BITS = 10;
    localparam int REACT_RAND_MIN  = 1000;

    // What the divider does on the coming clock edge.
    typedef enum logic [1:0] {
        DIV_HOLD  = 2'd0,   // en low: count and tog frozen
        DIV_COUNT = 2'd1,   // advance the count
        DIV_WRAP  = 2'd2,   // terminal count: wrap, tick, toggle
        DIV_LOAD  = 2'd3    // new divisor: restart the period
    } div_op_e;

    // One LFSR step. An all-zero state can never be left by XOR feedback,
    // so it is replaced by the seed instead of being shifted.
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] state,
        input logic [LFSR_W-1:0] seed
    );
        if (state == '0) begin
            return seed;
        end
        return {state[LFSR_W-2:0], ^(state & LFSR_POLY)};
    endfunction

endpackage : timebase_rng_pkg

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   Free-running 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) that
//   advances on every clock. A zero state, which the feedback could never
//   leave, is detected and replaced by SEED on the next edge.
//
//   Parameters:
//     SEED   reset value and lock-out recovery value; must be nonzero
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset, loads SEED
//     state  current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
    import timebase_rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_step(lfsr_q, SEED);
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule : lfsr16

// File: rtl/timebase_rng.sv
// ---------------------------------------------------------------------------
// timebase_rng
//   Timebase and random-delay source for the reaction-time monitor.
//   - Runtime-loadable divider producing a one-cycle tick enable every d
//     enabled clocks (d = max(divisor, 1)) and a tog square wave that flips
//     on each tick. All on clk; no derived clocks.
//   - A free-running LFSR; a synchronised rising edge of start captures
//     rand_out = RAND_MIN + lfsr[RAND_BITS-1:0], saturated to RAND_W bits,
//     and pulses rand_valid for one cycle.
//
//   Parameters:
//     DIV_W        divider counter / divisor width
//     DIV_DEFAULT  divisor loaded at reset
//     RAND_W       rand_out width (16 or less)
//     RAND_BITS    LFSR bits used as the random offset (RAND_W or less)
//     RAND_MIN     minimum rand_out value
//     LFSR_SEED    LFSR reset seed (nonzero)
//   Ports:
//     clk          system clock
//     rst          asynchronous active-low reset
//     en           divider run enable
//     div_val      new divisor value (0 loads as 1)
//     div_load     load div_val; restarts the period, overrides en
//     tick         one-cycle pulse every d enabled cycles
//     tog          toggles on every tick
//     start        asynchronous capture request (pushbutton domain)
//     rand_valid   one-cycle pulse when rand_out is updated
//     rand_out     captured random delay
// ---------------------------------------------------------------------------
module timebase_rng
    import timebase_rng_pkg::*;
#(
    parameter int                DIV_W       = 26,
    parameter int                DIV_DEFAULT = DIV_DEFAULT_50MHZ,
    parameter int                RAND_W      = REACT_RAND_W,
    parameter int                RAND_BITS   = REACT_RAND_BITS,
    parameter int                RAND_MIN    = REACT_RAND_MIN,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              div_load,
    output logic              tick,
    output logic              tog,
    input  logic              start,
    output logic              rand_valid,
    output logic [RAND_W-1:0] rand_out
);

    // One extra bit holds the carry of RAND_MIN + offset; both operands fit
    // in RAND_W bits, so the sum always fits in RAND_W + 1.
    localparam int SUM_W = RAND_W + 1;

    // -----------------------------------------------------------------------
    // Divider
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] cnt_q,  cnt_d;
    logic [DIV_W-1:0] div_q,  div_d;
    logic             tick_q, tick_d;
    logic             tog_q,  tog_d;
    logic [DIV_W-1:0] div_eff;
    div_op_e          div_op;

    // Decode what the divider does this cycle. Load outranks everything,
    // so a tick due in the load cycle is dropped.
    always_comb begin
        div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
        if (div_load) begin
            div_op = DIV_LOAD;
        end else if (!en) begin
            div_op = DIV_HOLD;
        end else if (cnt_q == div_eff - DIV_W'(1)) begin
            div_op = DIV_WRAP;
        end else begin
            div_op = DIV_COUNT;
        end
    end

    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
        tog_d  = tog_q;
        unique case (div_op)
            DIV_LOAD: begin
                div_d = (div_val == '0) ? DIV_W'(1) : div_val;
                cnt_d = '0;
            end
            DIV_WRAP: begin
                cnt_d  = '0;
                tick_d = 1'b1;
                tog_d  = ~tog_q;
            end
            DIV_COUNT: begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            default: begin
                // DIV_HOLD: count and tog keep their values, tick drops
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            div_q  <= DIV_W'(DIV_DEFAULT);
            tick_q <= 1'b0;
            tog_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            tog_q  <= tog_d;
        end
    end

    assign tick = tick_q;
    assign tog  = tog_q;

    // -----------------------------------------------------------------------
    // Random source
    // -----------------------------------------------------------------------
    logic [LFSR_W-1:0] lfsr_state;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst),
        .state (lfsr_state)
    );

    // Only the low RAND_BITS feed the offset; the rest are deliberately idle.
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_state;

    // -----------------------------------------------------------------------
    // start synchroniser and capture
    // -----------------------------------------------------------------------
    // sync[0] may go metastable; sync[1] is the first trusted sample and
    // sync[2] its one-cycle history for edge detection.
    logic [2:0]        sync_q, sync_d;
    logic              start_rise;
    logic [SUM_W-1:0]  rand_sum;
    logic [RAND_W-1:0] rand_q, rand_d;
    logic              valid_q, valid_d;

    always_comb begin
        sync_d     = {sync_q[1:0], start};
        start_rise = sync_q[1] & ~sync_q[2];
        rand_sum   = SUM_W'(RAND_MIN) + SUM_W'(lfsr_state[RAND_BITS-1:0]);
        valid_d    = start_rise;
        rand_d     = rand_q;
        if (start_rise) begin
            // A carry out of RAND_W bits means the range overflowed: clamp.
            rand_d = rand_sum[RAND_W] ? '1 : rand_sum[RAND_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            rand_q  <= RAND_W'(RAND_MIN);
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
        end
    end

    assign rand_valid = valid_q;
    assign rand_out   = rand_q;

endmodule : timebase_rng

// File: tb/tb_timebase_rng.sv
// ---------------------------------------------------------------------------
// tb_timebase_rng
//   Directed bench for timebase_rng with DIV_DEFAULT=5 and LFSR_SEED=1.
//   A second instance with a narrow rand_out (11 bits, RAND_MIN=2000)
//   exercises the saturating capture path with the same LFSR sequence.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_timebase_rng;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        div_load = 1'b0;
    logic        start = 1'b0;
    logic [25:0] div_val = '0;

    logic        tick, tog, rand_valid;
    logic [12:0] rand_out;
    logic        sat_tick, sat_tog, sat_valid;
    logic [10:0] sat_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timebase_rng #(
        .DIV_W       (26),
        .DIV_DEFAULT (5),
        .RAND_W      (13),
        .RAND_BITS   (10),
        .RAND_MIN    (1000),
        .LFSR_SEED   (16'h0001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_val    (div_val),
        .div_load   (div_load),
        .tick       (tick),
        .tog        (tog),
        .start      (start),
        .rand_valid (rand_valid),
        .rand_out   (rand_out)
    );

    timebase_rng #(
        .DIV_W       (26),
        .DIV_DEFAULT (5),
        .RAND_W      (11),
        .RAND_BITS   (10),
        .RAND_MIN    (2000),
        .LFSR_SEED   (16'h0001)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_val    (div_val),
        .div_load   (div_load),
        .tick       (sat_tick),
        .tog        (sat_tog),
        .start      (start),
        .rand_valid (sat_valid),
        .rand_out   (sat_out)
    );

    // Reference LFSR: left-shifting Fibonacci, taps 16,14,13,11.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst)               m_lfsr <= 16'h0001;
        else if (m_lfsr == '0)  m_lfsr <= 16'h0001;
        else                    m_lfsr <= {m_lfsr[14:0],
                                           m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [31:0] exp_rand(input logic [15:0] l);
        return 32'd1000 + 32'(l[9:0]);
    endfunction

    function automatic logic [31:0] exp_sat(input logic [15:0] l);
        int s;
        s = 2000 + int'(l[9:0]);
        return (s > 2047) ? 32'd2047 : 32'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic        exp_tog;
        logic [15:0] cap_lfsr;
        logic [15:0] prev_lfsr;
        logic [31:0] held;
        int          pulses;

        // ---------------- reset state ----------------
        repeat (2) clk_step();
        check("rst_tick",     32'(tick),       32'd0);
        check("rst_tog",      32'(tog),        32'd0);
        check("rst_valid",    32'(rand_valid), 32'd0);
        check("rst_rand",     32'(rand_out),   32'd1000);
        check("rst_sat_rand", 32'(sat_out),    32'd2000);
        check("rst_cnt",      32'(dut.cnt_q),  32'd0);
        check("rst_div",      32'(dut.div_q),  32'd5);
        rst = 1'b1;
        en  = 1'b1;

        // ---------------- 1: divide by 5 ----------------
        exp_tog = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            clk_step();
            if (k % 5 == 0) exp_tog = ~exp_tog;
            check("t1_tick", 32'(tick), 32'(k % 5 == 0));
            check("t1_tog",  32'(tog),  32'(exp_tog));
            check("t1_cnt_max", 32'(dut.cnt_q < 26'd5), 32'd1);
        end

        // ---------------- 2: pause at cnt=2 ----------------
        repeat (2) begin
            clk_step();
            check("t2_tick_pre", 32'(tick), 32'd0);
        end
        check("t2_cnt_at_pause", 32'(dut.cnt_q), 32'd2);
        en = 1'b0;
        repeat (7) begin
            clk_step();
            check("t2_tick_paused", 32'(tick), 32'd0);
            check("t2_tog_paused",  32'(tog),  32'(exp_tog));
        end
        check("t2_cnt_held", 32'(dut.cnt_q), 32'd2);
        en = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            clk_step();
            if (j == 3) exp_tog = ~exp_tog;
            check("t2_tick_resume", 32'(tick), 32'(j == 3));
            check("t2_tog_resume",  32'(tog),  32'(exp_tog));
        end

        // ---------------- 3: load 3 at cnt=4, then load 0 ----------------
        repeat (4) begin
            clk_step();
            check("t3_tick_pre", 32'(tick), 32'd0);
        end
        check("t3_cnt4", 32'(dut.cnt_q), 32'd4);
        div_val  = 26'd3;
        div_load = 1'b1;
        clk_step();
        check("t3_load_no_tick", 32'(tick),      32'd0);
        check("t3_load_tog",     32'(tog),       32'(exp_tog));
        check("t3_load_cnt",     32'(dut.cnt_q), 32'd0);
        div_load = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            clk_step();
            if (k % 3 == 0) exp_tog = ~exp_tog;
            check("t3_tick_div3", 32'(tick), 32'(k % 3 == 0));
            check("t3_tog_div3",  32'(tog),  32'(exp_tog));
        end
        div_val  = 26'd0;
        div_load = 1'b1;
        clk_step();
        check("t3_load0_no_tick", 32'(tick),      32'd0);
        check("t3_load0_div",     32'(dut.div_q), 32'd1);
        div_load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            clk_step();
            exp_tog = ~exp_tog;
            check("t3_tick_div1", 32'(tick), 32'd1);
            check("t3_tog_div1",  32'(tog),  32'(exp_tog));
        end

        // ---------------- 4: single start pulse ----------------
        en    = 1'b0;
        start = 1'b1;
        clk_step();
        check("t4_valid_e1", 32'(rand_valid), 32'd0);
        check("t4_lfsr_seq", 32'(dut.lfsr_state), 32'(m_lfsr));
        clk_step();
        check("t4_valid_e2", 32'(rand_valid), 32'd0);
        cap_lfsr = m_lfsr;
        clk_step();
        check("t4_valid_e3", 32'(rand_valid), 32'd1);
        check("t4_rand",     32'(rand_out),   exp_rand(cap_lfsr));
        check("t4_range",    32'(rand_out >= 13'd1000 && rand_out <= 13'd2023), 32'd1);
        check("t4_sat_valid", 32'(sat_valid), 32'd1);
        check("t4_sat_rand",  32'(sat_out),   exp_sat(cap_lfsr));
        check("t4_tick_off",  32'(tick),      32'd0);
        held  = 32'(rand_out);
        start = 1'b0;
        repeat (6) begin
            clk_step();
            check("t4_valid_once", 32'(rand_valid), 32'd0);
            check("t4_rand_hold",  32'(rand_out),   held);
        end

        // ---------------- 5: start held, released, re-asserted ----------------
        pulses    = 0;
        start     = 1'b1;
        prev_lfsr = m_lfsr;
        for (int i = 1; i <= 100; i++) begin
            clk_step();
            check("t5_valid_hold", 32'(rand_valid), 32'(i == 3));
            if (rand_valid) begin
                pulses++;
                check("t5_rand_1", 32'(rand_out), exp_rand(prev_lfsr));
                check("t5_sat_1",  32'(sat_out),  exp_sat(prev_lfsr));
                held = 32'(rand_out);
            end else if (i > 3) begin
                check("t5_rand_stable", 32'(rand_out), held);
            end
            prev_lfsr = m_lfsr;
        end
        start = 1'b0;
        repeat (5) begin
            clk_step();
            check("t5_valid_low",  32'(rand_valid), 32'd0);
            check("t5_rand_stable_low", 32'(rand_out), held);
        end
        start     = 1'b1;
        prev_lfsr = m_lfsr;
        for (int i = 1; i <= 10; i++) begin
            clk_step();
            check("t5_valid_again", 32'(rand_valid), 32'(i == 3));
            if (rand_valid) begin
                pulses++;
                check("t5_rand_2", 32'(rand_out), exp_rand(prev_lfsr));
                check("t5_sat_2",  32'(sat_out),  exp_sat(prev_lfsr));
            end
            prev_lfsr = m_lfsr;
        end
        check("t5_pulse_count", 32'(pulses), 32'd2);
        start = 1'b0;
        repeat (4) clk_step();

        // ---------------- 6a: reset mid-period ----------------
        en       = 1'b1;
        div_val  = 26'd5;
        div_load = 1'b1;
        clk_step();
        div_load = 1'b0;
        repeat (3) begin
            clk_step();
            check("t6_tick_pre", 32'(tick), 32'd0);
        end
        check("t6_cnt3", 32'(dut.cnt_q), 32'd3);
        #3;
        rst = 1'b0;
        #1;
        check("t6a_tick",  32'(tick),       32'd0);
        check("t6a_tog",   32'(tog),        32'd0);
        check("t6a_valid", 32'(rand_valid), 32'd0);
        check("t6a_rand",  32'(rand_out),   32'd1000);
        check("t6a_cnt",   32'(dut.cnt_q),  32'd0);
        clk_step();
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            clk_step();
            check("t6a_tick_after", 32'(tick),       32'(k == 5));
            check("t6a_tog_after",  32'(tog),        32'(k == 5));
            check("t6a_valid_after", 32'(rand_valid), 32'd0);
        end

        // ---------------- 6b: reset just after a capture ----------------
        en    = 1'b0;
        start = 1'b1;
        cap_lfsr = m_lfsr;
        for (int k = 1; k <= 3; k++) begin
            clk_step();
            if (k == 2) cap_lfsr = m_lfsr;
        end
        check("t6b_valid_cap", 32'(rand_valid), 32'd1);
        check("t6b_rand_cap",  32'(rand_out),   exp_rand(cap_lfsr));
        #3;
        rst = 1'b0;
        #1;
        check("t6b_valid_rst", 32'(rand_valid), 32'd0);
        check("t6b_rand_rst",  32'(rand_out),   32'd1000);
        check("t6b_sat_rst",   32'(sat_out),    32'd2000);
        start = 1'b0;
        clk_step();
        rst = 1'b1;
        repeat (6) begin
            clk_step();
            check("t6b_no_valid", 32'(rand_valid), 32'd0);
            check("t6b_no_tick",  32'(tick),       32'd0);
            check("t6b_rand_rst_hold", 32'(rand_out), 32'd1000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_timebase_rng
